// File: rtl/vga_text_pkg.sv
// vga_text_pkg: shared control codes, FSM/cursor enums and default geometry for the text console
package vga_text_pkg;
    localparam int N_COL_DEF = 80;
    localparam int N_ROW_DEF = 30;
    localparam logic [7:0] CHR_BS = 8'h08;
    localparam logic [7:0] CHR_LF = 8'h0A;
    localparam logic [7:0] CHR_FF = 8'h0C;
    localparam logic [7:0] CHR_CR = 8'h0D;
    typedef enum logic [2:0] {ST_IDLE, ST_PUT, ST_SCR_RD, ST_SCR_WAIT, ST_SCR_WR, ST_CLR} state_e;
    typedef enum logic [2:0] {CUR_NOP, CUR_INC, CUR_LF, CUR_CR, CUR_BS, CUR_HOME} cur_cmd_e;
    function automatic logic is_printable(input logic [7:0] c);
        return c >= 8'h20 && c != 8'h7F;
    endfunction
endpackage

// File: rtl/console_cursor.sv
// console_cursor: row/col cursor counters driven by one-hot-in-time commands from the console FSM
module console_cursor
    import vga_text_pkg::*;
#(
    parameter int N_COL = N_COL_DEF,
    parameter int N_ROW = N_ROW_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  cur_cmd_e                 cmd,
    output logic [$clog2(N_ROW)-1:0] row,
    output logic [$clog2(N_COL)-1:0] col,
    output logic                     last_row_hit
);
    localparam int RW = $clog2(N_ROW);
    localparam int CW = $clog2(N_COL);
    localparam logic [RW-1:0] ROW_LAST = RW'(N_ROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(N_COL - 1);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          col_last;

    assign row = row_q;
    assign col = col_q;
    assign last_row_hit = row_q == ROW_LAST;
    assign col_last = col_q == COL_LAST;

    // Row saturates at the last row; the FSM scrolls the RAM instead of moving the cursor
    always_comb begin
        col_d = (cmd == CUR_HOME || cmd == CUR_CR) ? '0 :
                cmd == CUR_INC ? (col_last ? '0 : col_q + 1'b1) :
                (cmd == CUR_BS && col_q != '0) ? col_q - 1'b1 : col_q;
        row_d = cmd == CUR_HOME ? '0 :
                ((cmd == CUR_LF || (cmd == CUR_INC && col_last)) && !last_row_hit) ? row_q + 1'b1 : row_q;
    end

    // Cursor registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/text_console_writer.sv
// text_console_writer: byte stream to character-RAM writer with cursor, scroll and clear; TEXT_CONSOLE_VBLANK_SYNC_EN gates RAM strobes to vBlank
module text_console_writer
    import vga_text_pkg::*;
#(
    parameter int          N_COL          = N_COL_DEF,
    parameter int          N_ROW          = N_ROW_DEF,
    parameter int          TEXTADDR_WIDTH = $clog2(N_COL * N_ROW),
    parameter int          RD_LATENCY     = 1,
    parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
    input  logic                     cpu_clk,
    input  logic                     rst_p,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_char,
    input  logic [7:0]               in_attr,
    input  logic                     vBlank,
    output logic [15:0]              cpu_addr,
    output logic                     cpu_we,
    output logic                     cpu_oe,
    output logic [15:0]              cpu_dataIn,
    input  logic [15:0]              cpu_dataOut,
    output logic                     busy,
    output logic [$clog2(N_ROW)-1:0] cursor_row,
    output logic [$clog2(N_COL)-1:0] cursor_col
);
    localparam int CELLS = N_COL * N_ROW;
    localparam int IW = $clog2(CELLS);
    localparam int CW = $clog2(N_COL);
    localparam logic [IW-1:0] CELL_LAST = IW'(CELLS - 1);
    localparam logic [IW-1:0] SCR_LAST  = IW'(CELLS - N_COL - 1);
    localparam logic [IW-1:0] CLR_FIRST = IW'(CELLS - N_COL);
    localparam logic [CW-1:0] COL_LAST  = CW'(N_COL - 1);
    localparam logic [7:0]    WAIT_LAST = 8'(RD_LATENCY - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    wcnt_q, wcnt_d, attr_q, attr_d, char_q, char_d;
    logic          cpu_we_q, cpu_we_d, cpu_oe_q, cpu_oe_d;
    logic [15:0]   addr_q, addr_d, data_q, data_d;
    logic [31:0]   lin;
    cur_cmd_e      cmd;
    logic          accept, fired, go, stall, last_row_hit;

    function automatic logic [15:0] to_addr(input logic [31:0] a);
        return 16'(a[TEXTADDR_WIDTH-1:0]);
    endfunction

`ifdef TEXT_CONSOLE_VBLANK_SYNC_EN
    assign go = vBlank;
`else
    logic unused_vblank;
    assign unused_vblank = vBlank;
    assign go = 1'b1;
`endif

    assign in_ready   = state_q == ST_IDLE && !rst_p;
    assign accept     = in_valid && in_ready;
    assign fired      = cpu_we_q | cpu_oe_q;
    assign busy       = state_q != ST_IDLE;
    assign cpu_we     = cpu_we_q;
    assign cpu_oe     = cpu_oe_q;
    assign cpu_addr   = addr_q;
    assign cpu_dataIn = data_q;

    console_cursor #(.N_COL(N_COL), .N_ROW(N_ROW)) u_cursor (
        .clk          (cpu_clk),
        .rst          (rst_p),
        .cmd          (cmd),
        .row          (cursor_row),
        .col          (cursor_col),
        .last_row_hit (last_row_hit)
    );

    // State register
    always_ff @(posedge cpu_clk or posedge rst_p) begin
        if (rst_p) state_q <= ST_IDLE;
        else state_q <= state_d;
    end

    // Next state: access states advance only once their strobe has actually gone out
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wcnt_d  = wcnt_q;
        cmd     = CUR_NOP;
        attr_d  = accept ? in_attr : attr_q;
        char_d  = accept ? in_char : char_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                if (is_printable(in_char)) state_d = ST_PUT;
                else if (in_char == CHR_CR) cmd = CUR_CR;
                else if (in_char == CHR_BS) cmd = CUR_BS;
                else if (in_char == CHR_LF) begin
                    cmd     = CUR_LF;
                    state_d = last_row_hit ? ST_SCR_RD : ST_IDLE;
                    idx_d   = '0;
                end else if (in_char == CHR_FF) begin
                    state_d = ST_CLR;
                    idx_d   = '0;
                end
            end
            ST_PUT: if (fired) begin
                cmd     = CUR_INC;
                state_d = (last_row_hit && cursor_col == COL_LAST) ? ST_SCR_RD : ST_IDLE;
                idx_d   = '0;
            end
            ST_SCR_RD: if (fired) begin
                state_d = ST_SCR_WAIT;
                wcnt_d  = '0;
            end
            ST_SCR_WAIT: begin
                wcnt_d  = wcnt_q + 8'd1;
                state_d = wcnt_q == WAIT_LAST ? ST_SCR_WR : ST_SCR_WAIT;
            end
            ST_SCR_WR: if (fired) begin
                state_d = idx_q == SCR_LAST ? ST_CLR : ST_SCR_RD;
                idx_d   = idx_q == SCR_LAST ? CLR_FIRST : idx_q + 1'b1;
            end
            ST_CLR: if (fired) begin
                state_d = idx_q == CELL_LAST ? ST_IDLE : ST_CLR;
                idx_d   = idx_q + 1'b1;
                cmd     = (idx_q == CELL_LAST && char_q == CHR_FF) ? CUR_HOME : CUR_NOP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered RAM outputs for the state being entered; a stalled access keeps its address and data
    always_comb begin
        lin      = 32'(cursor_row) * 32'(N_COL) + 32'(cursor_col);
        stall    = state_d == state_q && !fired &&
                   (state_q == ST_PUT || state_q == ST_SCR_RD || state_q == ST_SCR_WR || state_q == ST_CLR);
        cpu_we_d = go && (state_d == ST_PUT || state_d == ST_SCR_WR || state_d == ST_CLR);
        cpu_oe_d = go && state_d == ST_SCR_RD;
        addr_d   = stall ? addr_q :
                   state_d == ST_PUT ? to_addr(lin) :
                   state_d == ST_SCR_RD ? to_addr(32'(idx_d) + 32'(N_COL)) :
                   (state_d == ST_SCR_WR || state_d == ST_CLR) ? to_addr(32'(idx_d)) : addr_q;
        data_d   = stall ? data_q :
                   state_d == ST_PUT ? {attr_d, char_d} :
                   state_d == ST_SCR_WR ? cpu_dataOut :
                   state_d == ST_CLR ? {attr_d, BLANK_CHAR} : data_q;
    end

    // Datapath and output registers
    always_ff @(posedge cpu_clk or posedge rst_p) begin
        if (rst_p) begin
            idx_q    <= '0;
            wcnt_q   <= '0;
            attr_q   <= '0;
            char_q   <= '0;
            cpu_we_q <= 1'b0;
            cpu_oe_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            wcnt_q   <= wcnt_d;
            attr_q   <= attr_d;
            char_q   <= char_d;
            cpu_we_q <= cpu_we_d;
            cpu_oe_q <= cpu_oe_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: table vectors plus scroll/clear/reset sequences checked by a write scoreboard
module tb_text_console_writer;
    localparam int NC = 80;
    localparam int NR = 30;
    localparam int CELLS = NC * NR;

    typedef struct {logic [15:0] addr; logic [15:0] data;} wr_t;
    typedef struct {logic [7:0] c; logic [7:0] a; logic we; logic [15:0] addr; int row; int col;} vec_t;

    logic        cpu_clk = 1'b0;
    logic        rst_p = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_char = 8'h00;
    logic [7:0]  in_attr = 8'h00;
    logic        vBlank;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_oe;
    logic [15:0] cpu_dataIn;
    logic [15:0] cpu_dataOut = 16'h0000;
    logic        busy;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    logic [15:0] mem [0:CELLS-1];
    logic        preload = 1'b0;
    wr_t         q[$];
    wr_t         mon_e;
    vec_t        vt[13];
    int          tests = 0;
    int          fails = 0;
    int          wr_cnt = 0;
    int          w0;

    text_console_writer dut (
        .cpu_clk     (cpu_clk),
        .rst_p       (rst_p),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_attr     (in_attr),
        .vBlank      (vBlank),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_oe      (cpu_oe),
        .cpu_dataIn  (cpu_dataIn),
        .cpu_dataOut (cpu_dataOut),
        .busy        (busy),
        .cursor_row  (cursor_row),
        .cursor_col  (cursor_col)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Character RAM model: synchronous write, read data valid one cycle after cpu_oe
    always @(posedge cpu_clk) begin
        if (preload) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= 16'(i);
        end else begin
            if (cpu_we && cpu_addr < 16'(CELLS)) mem[cpu_addr] <= cpu_dataIn;
            if (cpu_oe) cpu_dataOut <= cpu_addr < 16'(CELLS) ? mem[cpu_addr] : 16'hDEAD;
        end
    end

    // Scoreboard: every write strobe is matched in order against the expected queue
    always @(negedge cpu_clk) begin
        if (cpu_we && cpu_oe) begin
            tests++;
            fails++;
            $display("FAIL we_oe_overlap: both strobes high at addr %h", cpu_addr);
        end
        if (cpu_we) begin
            wr_cnt++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", cpu_addr, cpu_dataIn);
            end else begin
                mon_e = q.pop_front();
                if (cpu_addr !== mon_e.addr || cpu_dataIn !== mon_e.data) begin
                    fails++;
                    $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                             cpu_addr, cpu_dataIn, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cpu_clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int n = 0;
        while (!in_ready && n < 20000) begin
            tick(1);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for char %h", c);
        end
        in_valid = 1'b1;
        in_char = c;
        in_attr = a;
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy || !in_ready) && n < budget) begin
            tick(1);
            n++;
        end
        chk({name, "_idle"}, int'(busy), 0);
        tick(2);
    endtask

    task automatic push(input int addr, input logic [15:0] data);
        q.push_back('{16'(addr), data});
    endtask

    task automatic push_scroll(input logic [7:0] attr);
        for (int i = 0; i < CELLS - NC; i++) push(i, mem[i + NC]);
        for (int i = CELLS - NC; i < CELLS; i++) push(i, {attr, 8'h20});
    endtask

    initial begin
`ifdef TEXT_CONSOLE_VBLANK_SYNC_EN
        vBlank = 1'b1;
`else
        vBlank = 1'b0;
`endif
        vt[0]  = '{8'h41, 8'h1F, 1'b1, 16'd0,  0, 1};
        vt[1]  = '{8'h62, 8'h02, 1'b1, 16'd1,  0, 2};
        vt[2]  = '{8'h0D, 8'h00, 1'b0, 16'd0,  0, 0};
        vt[3]  = '{8'h0A, 8'h00, 1'b0, 16'd0,  1, 0};
        vt[4]  = '{8'h78, 8'h30, 1'b1, 16'd80, 1, 1};
        vt[5]  = '{8'h08, 8'h00, 1'b0, 16'd0,  1, 0};
        vt[6]  = '{8'h08, 8'h00, 1'b0, 16'd0,  1, 0};
        vt[7]  = '{8'h00, 8'h00, 1'b0, 16'd0,  1, 0};
        vt[8]  = '{8'h7F, 8'h00, 1'b0, 16'd0,  1, 0};
        vt[9]  = '{8'h80, 8'h11, 1'b1, 16'd80, 1, 1};
        vt[10] = '{8'hFF, 8'h22, 1'b1, 16'd81, 1, 2};
        vt[11] = '{8'h1B, 8'h00, 1'b0, 16'd0,  1, 2};
        vt[12] = '{8'h7E, 8'h44, 1'b1, 16'd82, 1, 3};

        tick(2);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_we", int'(cpu_we), 0);
        chk("rst_oe", int'(cpu_oe), 0);
        chk("rst_addr", int'(cpu_addr), 0);
        chk("rst_data", int'(cpu_dataIn), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_col", int'(cursor_col), 0);
        rst_p = 1'b0;
        tick(1);
        chk("rel_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 13; i++) begin
            if (vt[i].we) push(int'(vt[i].addr), {vt[i].a, vt[i].c});
            w0 = wr_cnt;
            send(vt[i].c, vt[i].a);
            chk($sformatf("vec%0d_ready_after_accept", i), int'(in_ready), int'(!vt[i].we));
            chk($sformatf("vec%0d_we_next_cycle", i), int'(cpu_we), int'(vt[i].we));
            tick(1);
            chk($sformatf("vec%0d_ready_back", i), int'(in_ready), 1);
            chk($sformatf("vec%0d_row", i), int'(cursor_row), vt[i].row);
            chk($sformatf("vec%0d_col", i), int'(cursor_col), vt[i].col);
            chk($sformatf("vec%0d_writes", i), wr_cnt - w0, int'(vt[i].we));
        end

        send(8'h0D, 8'h00);
        for (int k = 0; k < 79; k++) begin
            push(NC + k, {8'h0A, 8'(8'h61 + k % 26)});
            send(8'(8'h61 + k % 26), 8'h0A);
        end
        push(NC + 79, 16'h1F5A);
        send(8'h5A, 8'h1F);
        wait_idle(100, "wrap");
        chk("wrap_row", int'(cursor_row), 2);
        chk("wrap_col", int'(cursor_col), 0);
        for (int k = 0; k < 5; k++) begin
            push(2 * NC + k, 16'h0763);
            send(8'h63, 8'h07);
        end
        wait_idle(100, "pre_cr");
        w0 = wr_cnt;
        send(8'h0D, 8'h00);
        chk("cr_ready", int'(in_ready), 1);
        tick(2);
        chk("cr_col", int'(cursor_col), 0);
        chk("cr_row", int'(cursor_row), 2);
        chk("cr_no_write", wr_cnt - w0, 0);

        for (int k = 0; k < 27; k++) send(8'h0A, 8'h00);
        for (int k = 0; k < 3; k++) begin
            push((NR - 1) * NC + k, 16'h016B);
            send(8'h6B, 8'h01);
        end
        wait_idle(100, "pre_scroll");
        chk("lastrow_row", int'(cursor_row), 29);
        preload = 1'b1;
        tick(1);
        preload = 1'b0;
        tick(1);
        push_scroll(8'h05);
        send(8'h0A, 8'h05);
        chk("lf_scroll_busy", int'(busy), 1);
        wait_idle(10000, "lf_scroll");
        chk("lf_scroll_row", int'(cursor_row), 29);
        chk("lf_scroll_col", int'(cursor_col), 3);
        chk("lf_scroll_pending", q.size(), 0);
        chk("lf_scroll_ram_2319", int'(mem[2319]), 2399);

        send(8'h0D, 8'h00);
        for (int k = 0; k < 79; k++) begin
            push((NR - 1) * NC + k, {8'h0B, 8'h6D});
            send(8'h6D, 8'h0B);
        end
        wait_idle(100, "pre_wrap_scroll");
        chk("prewrap_col", int'(cursor_col), 79);
        push(CELLS - 1, 16'h3C51);
        for (int i = 0; i < CELLS - NC; i++) push(i, i + NC == CELLS - 1 ? 16'h3C51 : mem[i + NC]);
        for (int i = CELLS - NC; i < CELLS; i++) push(i, 16'h3C20);
        send(8'h51, 8'h3C);
        wait_idle(10000, "wrap_scroll");
        chk("wrap_scroll_row", int'(cursor_row), 29);
        chk("wrap_scroll_col", int'(cursor_col), 0);
        chk("wrap_scroll_pending", q.size(), 0);

        for (int i = 0; i < CELLS; i++) push(i, 16'h0720);
        send(8'h0C, 8'h07);
        wait_idle(5000, "ff");
        chk("ff_row", int'(cursor_row), 0);
        chk("ff_col", int'(cursor_col), 0);
        chk("ff_busy", int'(busy), 0);
        chk("ff_pending", q.size(), 0);
        chk("ff_ram_last", int'(mem[CELLS - 1]), 16'h0720);

`ifdef TEXT_CONSOLE_VBLANK_SYNC_EN
        vBlank = 1'b0;
        push(0, 16'h0142);
        w0 = wr_cnt;
        send(8'h42, 8'h01);
        tick(5);
        chk("vb_held_writes", wr_cnt - w0, 0);
        chk("vb_held_busy", int'(busy), 1);
        vBlank = 1'b1;
        tick(4);
        chk("vb_release_writes", wr_cnt - w0, 1);
        chk("vb_col", int'(cursor_col), 1);
        vBlank = 1'b0;
        send(8'h0D, 8'h00);
        vBlank = 1'b1;
`endif

        for (int k = 0; k < 29; k++) send(8'h0A, 8'h00);
        wait_idle(100, "pre_abort");
        push_scroll(8'h00);
        send(8'h0A, 8'h00);
        tick(50);
        chk("abort_busy_before", int'(busy), 1);
        #2 rst_p = 1'b1;
        #1;
        chk("abort_we", int'(cpu_we), 0);
        chk("abort_oe", int'(cpu_oe), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_row", int'(cursor_row), 0);
        chk("abort_col", int'(cursor_col), 0);
        tick(2);
        #2 rst_p = 1'b0;
        q.delete();
        tick(1);
        chk("abort_rel_ready", int'(in_ready), 1);
        push(0, 16'h1F41);
        send(8'h41, 8'h1F);
        wait_idle(100, "post_abort");
        chk("post_abort_col", int'(cursor_col), 1);
        chk("post_abort_pending", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
